cond_issue_ctrl: RTL and testbench

Condition-execution controller between decode and execute of the ARM datapath. It holds the architectural NZCV flag register and evaluates each incoming instruction's 4-bit condition code against the flags. It stalls issue while an earlier flag-setting instruction has not yet returned its ALU flags, and registers a pass/branch-taken decision toward execute through a valid/ready handshake.

---
 rtl/arm_cond_pkg.sv | 36 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_issue_ctrl.sv | 105 ++++++++++
 tb/tb_cond_issue_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// arm_cond_pkg: ARM condition-code constants, NZCV bit positions and
// the issue-controller state encoding shared by the decode/execute logic.
`default_nettype none

package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_WAIT_FLAGS = 1'b1
  } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluation (cc, NZCV -> pass).
`default_nettype none

module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  always_comb begin
    pass = 1'b0;
    unique case (cc)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl: holds NZCV, stalls behind an outstanding flag-setting
// instruction and registers the pass/branch decision toward execute.
`default_nettype none

module cond_issue_ctrl
  import arm_cond_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_cc,
  input  logic                   in_set_flags,
  input  logic                   in_is_branch,
  input  logic                   alu_flags_valid,
  input  logic [3:0]             alu_nzcv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_pass,
  output logic                   out_branch_taken,
  input  logic                   flush,
  output logic [3:0]             flags,
  output logic                   flag_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  issue_state_e state, state_next;
  logic [3:0]   eff_flags;
  logic         cond_pass;
  logic         accept;
  logic         take;
  logic         stall_cycle;

  // Forward ALU flags returned this cycle so a stalled instruction issues
  // on the very cycle its dependency resolves.
  assign eff_flags = alu_flags_valid ? alu_nzcv : flags;

  cond_check u_cond_check (
    .cc   (in_cc),
    .nzcv (eff_flags),
    .pass (cond_pass)
  );

  assign in_ready    = (~out_valid | out_ready) & ((state == ST_IDLE) | alu_flags_valid);
  assign accept      = in_valid & in_ready;
  assign take        = accept & ~flush;
  assign stall_cycle = in_valid & (state == ST_WAIT_FLAGS) & ~alu_flags_valid;

  always_comb begin
    state_next = state;
    if ((state == ST_WAIT_FLAGS) && alu_flags_valid)
      state_next = ST_IDLE;
    if (take && cond_pass && in_set_flags)
      state_next = ST_WAIT_FLAGS;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // A flag return with nothing outstanding is a protocol error; it never
  // touches the architectural flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags    <= 4'b0000;
      flag_err <= 1'b0;
    end else if (alu_flags_valid) begin
      if (state == ST_WAIT_FLAGS)
        flags <= alu_nzcv;
      else
        flag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_pass         <= 1'b0;
      out_branch_taken <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      out_pass         <= cond_pass;
      out_branch_taken <= cond_pass & in_is_branch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_cycle && (stall_cnt != {STALL_CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_cond_issue_ctrl.sv
// tb_cond_issue_ctrl: directed self-checking bench for cond_issue_ctrl.
`default_nettype none

module tb_cond_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_cc;
  logic        in_set_flags, in_is_branch;
  logic        alu_flags_valid;
  logic [3:0]  alu_nzcv;
  logic        out_valid, out_ready, out_pass, out_branch_taken;
  logic        flush;
  logic [3:0]  flags;
  logic        flag_err;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cond_issue_ctrl #(.STALL_CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_cc            (in_cc),
    .in_set_flags     (in_set_flags),
    .in_is_branch     (in_is_branch),
    .alu_flags_valid  (alu_flags_valid),
    .alu_nzcv         (alu_nzcv),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pass         (out_pass),
    .out_branch_taken (out_branch_taken),
    .flush            (flush),
    .flags            (flags),
    .flag_err         (flag_err),
    .stall_cnt        (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cc, input logic s, input logic br);
    in_valid     = v;
    in_cc        = cc;
    in_set_flags = s;
    in_is_branch = br;
  endtask

  initial begin
    logic [3:0] vec_cc   [6];
    logic       vec_pass [6];
    vec_cc[0] = 4'b1010; vec_pass[0] = 1'b1;  // GE
    vec_cc[1] = 4'b1011; vec_pass[1] = 1'b0;  // LT
    vec_cc[2] = 4'b1100; vec_pass[2] = 1'b1;  // GT
    vec_cc[3] = 4'b1111; vec_pass[3] = 1'b0;  // NV
    vec_cc[4] = 4'b1101; vec_pass[4] = 1'b0;  // LE
    vec_cc[5] = 4'b1000; vec_pass[5] = 1'b0;  // HI

    reset = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    alu_flags_valid = 1'b0;
    alu_nzcv        = 4'h0;
    out_ready       = 1'b1;
    flush           = 1'b0;
    step();
    step();

    check("rst_flags",     flags, 4'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pass",  out_pass, 1'b0);
    check("rst_branch",    out_branch_taken, 1'b0);
    check("rst_flag_err",  flag_err, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_in_ready",  in_ready, 1'b1);
    reset = 1'b0;
    step();

    // NE branch with Z=0: taken one cycle later
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    step();
    check("ne_valid",  out_valid, 1'b1);
    check("ne_pass",   out_pass, 1'b1);
    check("ne_branch", out_branch_taken, 1'b1);

    // AL S instruction, then dependent EQ stalls for 3 cycles
    drive(1'b1, 4'b1110, 1'b1, 1'b0);
    #1;
    check("s_in_ready_before", in_ready, 1'b1);
    step();
    check("s_pass",   out_pass, 1'b1);
    check("s_branch", out_branch_taken, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    step();
    step();
    step();
    check("stall_cnt_3",     stall_cnt, 16'd3);
    check("stall_out_valid", out_valid, 1'b0);
    alu_flags_valid = 1'b1;
    alu_nzcv        = 4'b0100;
    #1;
    check("fwd_in_ready", in_ready, 1'b1);
    step();
    check("fwd_valid",     out_valid, 1'b1);
    check("fwd_pass",      out_pass, 1'b1);
    check("fwd_flags",     flags, 4'b0100);
    check("fwd_stall_cnt", stall_cnt, 16'd3);
    check("fwd_flag_err",  flag_err, 1'b0);
    alu_flags_valid = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("fwd_idle_ready", in_ready, 1'b1);

    // Load flags = 1001 (N=1, V=1)
    drive(1'b1, 4'b1110, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    alu_flags_valid = 1'b1;
    alu_nzcv        = 4'b1001;
    step();
    alu_flags_valid = 1'b0;
    check("flags_1001", flags, 4'b1001);

    // Signed comparisons back to back, all as branches
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vec_cc[i], 1'b0, 1'b1);
      #1;
      check($sformatf("cc_%b_ready", vec_cc[i]), in_ready, 1'b1);
      step();
      check($sformatf("cc_%b_pass", vec_cc[i]), out_pass, vec_pass[i]);
      check($sformatf("cc_%b_branch", vec_cc[i]), out_branch_taken, vec_pass[i]);
    end

    // Backpressure: decision held while execute is not ready
    drive(1'b1, 4'b1110, 1'b0, 1'b1);
    step();
    check("bp_pass0", out_pass, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      step();
      check("bp_valid",  out_valid, 1'b1);
      check("bp_pass",   out_pass, 1'b1);
      check("bp_branch", out_branch_taken, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    step();
    check("bp_next_valid",  out_valid, 1'b1);
    check("bp_next_pass",   out_pass, 1'b0);
    check("bp_next_branch", out_branch_taken, 1'b0);
    check("bp_stall_cnt",   stall_cnt, 16'd3);

    // Failing S instruction (EQ with Z=0) leaves no flag dependency
    drive(1'b1, 4'b0000, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("fail_s_pass",  out_pass, 1'b0);
    check("fail_s_ready", in_ready, 1'b1);
    alu_flags_valid = 1'b1;
    alu_nzcv        = 4'b1111;
    step();
    alu_flags_valid = 1'b0;
    check("spurious_flag_err", flag_err, 1'b1);
    check("spurious_flags",    flags, 4'b1001);

    // Flush in the accept cycle of a passing S instruction
    drive(1'b1, 4'b1110, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);

    // Asynchronous reset while waiting on flags
    drive(1'b1, 4'b1110, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("wait_ready", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("arst_valid",    out_valid, 1'b0);
    check("arst_pass",     out_pass, 1'b0);
    check("arst_flags",    flags, 4'h0);
    check("arst_flag_err", flag_err, 1'b0);
    check("arst_stall",    stall_cnt, 16'd0);
    check("arst_ready",    in_ready, 1'b1);
    #1;
    reset = 1'b0;
    alu_flags_valid = 1'b1;
    alu_nzcv        = 4'b0110;
    step();
    alu_flags_valid = 1'b0;
    check("late_flag_err", flag_err, 1'b1);
    check("late_flags",    flags, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
